multiport_registerfile: RTL
===========================

# multiport_registerfile

Parametrised general-purpose register file for the MIPS datapath. It extends the two-read/one-write register file with configurable width, depth and read-port count, a write-to-read bypass, a hardwired zero register and a synchronous clear sweep on reset. It sits in the decode stage: read ports feed the operand latches and the write port is driven by writeback.

## Interface

Parameters:
- DATA_W, 32: register width in bits.
- ADDR_W, 5: address width; DEPTH = 2**ADDR_W entries.
- NUM_RD, 2: number of read ports, 1..4.
- ZERO_REG, 1: if 1, entry 0 always reads 0 and writes to it are discarded.
- INIT_ON_RESET, 1: if 1, reset triggers the clear sweep; if 0, reset leaves contents untouched.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
- clk, in, 1: the single clock; all state updates on the rising edge.
- rst, in, 1: synchronous, active-high reset.
- raddr, in, NUM_RD*ADDR_W: read addresses; port k uses bits [k*ADDR_W +: ADDR_W].
- rdata, out, NUM_RD*DATA_W: read data; port k uses bits [k*DATA_W +: DATA_W].
- regWflag, in, 1: write enable.
- regWaddr, in, ADDR_W: write address.
- data, in, DATA_W: write data.
- ready, out, 1: high when the file accepts writes and returns stored data.

## Operation

- Controller states are CLEAR and READY.
- Any edge with rst=1:
  - state <= CLEAR and cnt <= 0.
  - If INIT_ON_RESET=0, state <= READY instead.
- CLEAR with rst=0, each edge:
  - mem[cnt] <= 0.
  - If cnt == DEPTH-1, state <= READY; otherwise cnt <= cnt+1.
  - cnt is ADDR_W bits wide. The compare is made before the increment, so the counter never wraps.
- READY: an edge with regWflag=1 writes mem[regWaddr] <= data, unless ZERO_REG=1 and regWaddr=0.
- Writes during CLEAR or while rst=1 are ignored. There is no queueing and no error flag.
- Reads are combinational, and each port resolves in this priority order:
  1. If the controller is not in READY, rdata_k = 0.
  2. If ZERO_REG=1 and raddr_k = 0, rdata_k = 0.
  3. If regWflag=1 and regWaddr = raddr_k (bypass), rdata_k = data. This returns the value being written in the same cycle.
  4. Otherwise rdata_k = mem[raddr_k].
- Several ports may address the same entry, and each receives the identical value.
- Reset value of outputs: ready=0 and all rdata=0. The exception is INIT_ON_RESET=0, where rdata shows the retained contents once ready=1.

## Timing

- Write latency: the value is visible through the bypass in the same cycle and from the array after the next edge.
- Read latency: 0 cycles, combinational from raddr, regWflag, regWaddr and data.
- Clear sweep:
  - Deassert rst before edge E0. Entries 0..DEPTH-1 are cleared on edges E0..E(DEPTH-1).
  - ready rises after edge E(DEPTH-1), i.e. DEPTH cycles after reset release. With the defaults that is 32 cycles.
- INIT_ON_RESET=0: ready rises after the first edge with rst=0.
- Reset during CLEAR restarts the sweep from entry 0.
- Reset during READY drops ready on the following edge. A write presented on that same edge is ignored.
- No combinational path from any input to ready.

## Structure

- Shared package regfile_pkg:
  - RF_CLEAR and RF_READY state encodings as localparams.
  - Default width/depth constants shared with the decode stage.
- Sub-module regfile_clear_ctrl:
  - Contains the CLEAR/READY FSM and the sweep counter.
  - Outputs ready, clr_en and clr_addr.
- The top level holds the storage array, the write mux (clr_en selects the sweep write) and a generate loop of NUM_RD read/bypass muxes.

## Test plan

- Reset sweep:
  - Preload all entries with 0xFFFFFFFF using INIT_ON_RESET=1.
  - Pulse rst for 1 cycle.
  - Required: ready=0 for exactly 32 cycles and all rdata=0 throughout. After ready=1, every address reads 0.
- Write then read:
  - Write 0xDEADBEEF to r7.
  - Next cycle read r7 on both ports.
  - Required: 0xDEADBEEF on both.
- Bypass:
  - With r5=0x11, same-cycle write of 0x22 to r5 and read of r5 on port 0.
  - Required: rdata0=0x22 in that cycle, and still 0x22 after the edge.
- Zero register:
  - Write 0x1234 to r0 with a same-cycle read of r0.
  - Required: 0 in that cycle and in the following cycle.
- Reset mid-sweep:
  - Assert rst at sweep cycle 10, release, and write r3 during the sweep.
  - Required: ready rises 32 cycles after the second release, and r3 reads 0.
- Parameter variant:
  - DATA_W=16, ADDR_W=3, NUM_RD=4, INIT_ON_RESET=0.
  - Write 0xA5A5 to r6, then pulse rst.
  - Required: ready=1 one cycle after release, and r6 reads 0xA5A5 on all four ports.

Source files
------------

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared state encodings and default sizes for the register file
package regfile_pkg;

    localparam logic RF_CLEAR = 1'b0;
    localparam logic RF_READY = 1'b1;

    typedef enum logic {
        ST_CLEAR = RF_CLEAR,
        ST_READY = RF_READY
    } rf_state_e;

    // Defaults shared with the decode stage
    localparam int RF_DATA_W = 32;
    localparam int RF_ADDR_W = 5;
    localparam int RF_NUM_RD = 2;

endpackage

// File: rtl/regfile_clear_ctrl.sv
// rtl/regfile_clear_ctrl.sv - CLEAR/READY controller with the reset clear sweep counter
module regfile_clear_ctrl
    import regfile_pkg::*;
#(
    parameter int ADDR_W        = RF_ADDR_W,
    parameter int INIT_ON_RESET = 1
) (
    input  logic              clk,
    input  logic              rst,
    output logic              ready,
    output logic              clr_en,
    output logic [ADDR_W-1:0] clr_addr
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    rf_state_e         state_q;
    logic [ADDR_W-1:0] cnt_q;
    logic              ready_q;

    // ready is registered separately so it is 0 on every reset edge, even when the sweep is skipped
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= (INIT_ON_RESET != 0) ? ST_CLEAR : ST_READY;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    if (cnt_q == LAST_ADDR) begin
                        state_q <= ST_READY;
                        ready_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_READY: ready_q <= 1'b1;
                default: begin
                    state_q <= ST_CLEAR;
                    cnt_q   <= '0;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign ready    = ready_q;
    assign clr_en   = (state_q == ST_CLEAR) && !rst;
    assign clr_addr = cnt_q;

endmodule

// File: rtl/multiport_registerfile.sv
// rtl/multiport_registerfile.sv - parametrised multi-read register file with bypass, zero register and clear sweep
module multiport_registerfile
    import regfile_pkg::*;
#(
    parameter int DATA_W        = RF_DATA_W,
    parameter int ADDR_W        = RF_ADDR_W,
    parameter int NUM_RD        = RF_NUM_RD,
    parameter int ZERO_REG      = 1,
    parameter int INIT_ON_RESET = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*ADDR_W-1:0] raddr,
    output logic [NUM_RD*DATA_W-1:0] rdata,
    input  logic                     regWflag,
    input  logic [ADDR_W-1:0]        regWaddr,
    input  logic [DATA_W-1:0]        data,
    output logic                     ready
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              clr_en;
    logic [ADDR_W-1:0] clr_addr;
    logic              wr_en;

    regfile_clear_ctrl #(
        .ADDR_W       (ADDR_W),
        .INIT_ON_RESET(INIT_ON_RESET)
    ) u_clear_ctrl (
        .clk     (clk),
        .rst     (rst),
        .ready   (ready),
        .clr_en  (clr_en),
        .clr_addr(clr_addr)
    );

    assign wr_en = ready && regWflag && !rst && !((ZERO_REG != 0) && (regWaddr == '0));

    always_ff @(posedge clk) begin
        if (clr_en) begin
            mem_q[clr_addr] <= '0;
        end else if (wr_en) begin
            mem_q[regWaddr] <= data;
        end
    end

    // Later assignments win: not-ready beats zero register beats bypass beats array
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] rd;

        assign ra = raddr[k*ADDR_W +: ADDR_W];

        always_comb begin
            rd = mem_q[ra];
            if (regWflag && (regWaddr == ra)) rd = data;
            if ((ZERO_REG != 0) && (ra == '0)) rd = '0;
            if (!ready) rd = '0;
        end

        assign rdata[k*DATA_W +: DATA_W] = rd;
    end

endmodule
